// File: rtl/uart_alu_sequencer_if.sv
// uart_alu_sequencer_if: receiver, ALU and transmitter signals seen by the sequencer
interface uart_alu_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_err;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic                  o_tx_start;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_busy;
  logic                  o_err;
  modport master (
    output i_rx_done, i_rx_data, i_rx_err, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_err
  );
  modport slave (
    input  i_rx_done, i_rx_data, i_rx_err, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_err
  );
endinterface

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: collects A, B, opcode bytes from the UART and transmits the ALU result
module uart_alu_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input logic i_clock,
  input logic i_reset,
  uart_alu_sequencer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] WAIT_TX = 3'd4;
  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  tx_start_q, tx_start_d, err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  acc, bad;
  assign acc = bus.i_rx_done & ~bus.i_rx_err;
  assign bad = bus.i_rx_done & bus.i_rx_err;
  // next-state logic: byte collection, inter-byte timeout, launch and wait for transmit
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = err_q;
    cnt_d      = '0;
    case (state_q)
      WAIT_A: begin
        if (acc) begin
          a_d     = bus.i_rx_data;
          err_d   = 1'b0;
          state_d = WAIT_B;
        end else if (bad) begin
          err_d = 1'b1;
        end
      end
      WAIT_B, WAIT_OP: begin
        cnt_d = (bus.i_rx_done || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        if (acc) begin
          err_d = 1'b0;
          if (state_q == WAIT_B) begin
            b_d     = bus.i_rx_data;
            state_d = WAIT_OP;
          end else begin
            op_d    = bus.i_rx_data[OP_WIDTH-1:0];
            state_d = EXEC;
          end
        end else if (bad) begin
          err_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: state_d = bus.i_tx_done ? WAIT_A : WAIT_TX;
      default: state_d = WAIT_A;
    endcase
  end
  // state and output registers, reset wins over everything
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_err      = err_q;
  assign bus.o_busy     = state_q != WAIT_A;
endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Sits between the UART receiver and the UART transmitter inside TOP. Owns the ALU operand, opcode and result registers.
- Collects three received bytes in order: operand A, operand B, opcode. Drives the external combinational ALU, then launches one UART transmission of the ALU result.
- Ignores new input until the transmitter reports done. Resynchronises to "expect operand A" after an inter-byte timeout.

Parameters:
- DATA_WIDTH, 8: width of UART data bytes, operands and result.
- OP_WIDTH, 6: opcode width; taken from the low bits of the opcode byte.
- TIMEOUT_CYCLES, 131072: idle clock cycles allowed between bytes of one command before aborting.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  one-cycle pulse: received byte on i_rx_data is valid.
- i_rx_data  in  DATA_WIDTH  received byte.
- i_rx_err  in  1  parity/framing error; qualifies i_rx_done.
- i_alu_result  in  DATA_WIDTH  combinational ALU output.
- i_tx_done  in  1  one-cycle pulse: transmitter finished its stop bit.
- o_alu_a  out  DATA_WIDTH  registered operand A.
- o_alu_b  out  DATA_WIDTH  registered operand B.
- o_alu_op  out  OP_WIDTH  registered opcode.
- o_tx_start  out  1  one-cycle transmit request.
- o_tx_data  out  DATA_WIDTH  byte to transmit; stable from o_tx_start until i_tx_done.
- o_busy  out  1  high whenever the state is not WAIT_A.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high, i_clock domain only):
  - state <= WAIT_A.
  - All outputs 0; timeout counter 0.
  - Reset has priority over every other event, including mid-command and mid-transmission.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- A byte is "accepted" when i_rx_done=1 and i_rx_err=0. A byte is "bad" when i_rx_done=1 and i_rx_err=1.
- WAIT_A:
  - Accepted byte: o_alu_a <= i_rx_data, o_err <= 0, go to WAIT_B.
  - Bad byte: o_err <= 1, stay in WAIT_A.
- WAIT_B:
  - Accepted byte: o_alu_b <= i_rx_data, o_err <= 0, go to WAIT_OP.
  - Bad byte: o_err <= 1, stay in WAIT_B. The bad byte still counts as activity and resets the timeout counter.
- WAIT_OP:
  - Accepted byte: o_alu_op <= i_rx_data[OP_WIDTH-1:0], o_err <= 0, go to EXEC. Upper opcode-byte bits are ignored.
  - Bad byte: same handling as in WAIT_B.
- Timeout (WAIT_B and WAIT_OP only):
  - Counter increments every cycle with no i_rx_done; cleared on any i_rx_done and on every state entry.
  - When the counter equals TIMEOUT_CYCLES-1 with no i_rx_done that cycle: go to WAIT_A, o_err <= 1, counter <= 0.
  - Partial operands are not cleared.
  - Counter width is $clog2(TIMEOUT_CYCLES); it never wraps.
- EXEC (exactly one cycle):
  - o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
  - Latency: opcode i_rx_done at edge N gives o_alu_op valid after N, and o_tx_start high for the cycle after edge N+1 (two cycles after the opcode pulse).
- WAIT_TX:
  - o_tx_start <= 0 after one cycle.
  - o_alu_a, o_alu_b, o_alu_op and o_tx_data are held.
  - All i_rx_done pulses are dropped silently: no register update, o_err unchanged.
  - On i_tx_done go to WAIT_A. i_tx_done in any other state is ignored.
- Simultaneous i_tx_done and i_rx_done in WAIT_TX: go to WAIT_A; the byte is dropped, not taken as operand A.
- o_alu_a, o_alu_b and o_alu_op keep their last values across commands until overwritten.
- The block performs no arithmetic; the result width equals DATA_WIDTH.

Test Plan:
- Nominal (bench ALU model: 0x20=ADD, 0x22=SUB; TIMEOUT_CYCLES=100):
  - Stimulus: accepted bytes 0x03, 0x82, 0x20.
  - Required: o_alu_a=0x03, o_alu_b=0x82, o_alu_op=6'h20; o_tx_start high for exactly one cycle, 2 cycles after the opcode pulse; o_tx_data=0x85; o_busy=1 until one cycle after i_tx_done.
- Bad byte:
  - Stimulus: 0x03, then 0x82 with i_rx_err=1, then good 0x82, then 0x20.
  - Required: state stays WAIT_B and o_err=1 after the bad byte; o_err=0 once the good 0x82 is accepted; o_tx_data=0x85.
- Timeout:
  - Stimulus: 0x03, then no bytes for 100 cycles, then 0x10, 0x01, 0x22.
  - Required: o_err=1 and o_busy=0 after cycle 100; the next bytes are treated as a fresh A/B/op; o_tx_data=0x0F.
- Traffic during transmit:
  - Stimulus: 0x55 and 0xAA arrive during WAIT_TX.
  - Required: both ignored; o_alu_a stays 0x03 and o_tx_data stays 0x85 until i_tx_done.
- Simultaneous events:
  - Stimulus: i_tx_done and i_rx_done(0x77) in the same cycle.
  - Required: state becomes WAIT_A; o_alu_a is unchanged; the next byte 0x07 becomes A.
- Reset mid-command:
  - Stimulus: 0x03, 0x82, one-cycle i_reset, then 0x20.
  - Required: all outputs 0 after reset; 0x20 is latched as o_alu_a; o_tx_start does not fire.
